// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 fetch constants
package rv32_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/if_stage_ctrl_sat_counter.sv
// rtl/if_stage_ctrl_sat_counter.sv - saturating up-counter for performance events
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Count up by one per qualifying cycle, sticking at all-ones
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_stage_ctrl.sv
// rtl/if_stage_ctrl.sv - PC and IF/ID register with stall, redirect and flush handling
module if_stage_ctrl
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             IFIDWrite,
  input  logic             Bolha,
  input  logic             Flush,
  input  logic             Jump,
  input  logic [XLEN-1:0]  jump_target,
  input  logic [XLEN-1:0]  imem_instr,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  IFID_pc,
  output logic [XLEN-1:0]  IFID_pc4,
  output logic [XLEN-1:0]  IFID_instr,
  output logic             IFID_valid,
  output logic             misalign,
  output logic             ctrl_conflict,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            misalign_q, misalign_d;
  logic            conflict_q, conflict_d;

  logic            stall;
  logic            flush_taken;

  // Either write-enable low freezes the whole front end; a partial hold
  // would desynchronise pc from the instruction sitting in IF/ID.
  assign stall       = !PCWrite || !IFIDWrite;
  assign flush_taken = !stall && (Jump || Flush);

  // Next-state selection in priority order: stall, jump, flush, fetch
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = misalign_q;
    conflict_d   = 1'b0;
    if (stall) begin
      conflict_d = Jump || Flush;
    end else if (Jump) begin
      pc_d         = {jump_target[XLEN-1:2], 2'b00};
      ifid_pc_d    = pc_q;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      misalign_d   = misalign_q | (jump_target[1:0] != 2'b00);
    end else if (Flush) begin
      pc_d         = pc_q + PC_STEP;
      ifid_pc_d    = pc_q;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else begin
      pc_d         = pc_q + PC_STEP;
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem_instr;
      ifid_valid_d = 1'b1;
    end
  end

  // Front-end state registers; reset overrides any pending stall or redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      misalign_q   <= misalign_d;
      conflict_q   <= conflict_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!PCWrite),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_taken),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (Bolha),
    .count (bubble_cnt)
  );

  assign pc            = pc_q;
  assign IFID_pc       = ifid_pc_q;
  assign IFID_pc4      = ifid_pc_q + PC_STEP;
  assign IFID_instr    = ifid_instr_q;
  assign IFID_valid    = ifid_valid_q;
  assign misalign      = misalign_q;
  assign ctrl_conflict = conflict_q;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// tb/tb_if_stage_ctrl.sv - self-checking bench for if_stage_ctrl
module tb_if_stage_ctrl;

  localparam int          CNT_W = 16;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCWrite = 1'b1, IFIDWrite = 1'b1, Bolha = 1'b0, Flush = 1'b0, Jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] imem_instr;
  logic [31:0] pc, IFID_pc, IFID_pc4, IFID_instr;
  logic        IFID_valid, misalign, ctrl_conflict;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, bubble_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: combinational, PC-tagged words
  assign imem_instr = word_at(pc);

  if_stage_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .Bolha(Bolha), .Flush(Flush), .Jump(Jump), .jump_target(jump_target),
    .imem_instr(imem_instr), .pc(pc), .IFID_pc(IFID_pc), .IFID_pc4(IFID_pc4),
    .IFID_instr(IFID_instr), .IFID_valid(IFID_valid), .misalign(misalign),
    .ctrl_conflict(ctrl_conflict), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: architectural view of the fetch front end
  logic [31:0] m_pc, m_ipc, m_instr;
  bit          m_valid, m_mis, m_cc, m_ok = 0, held;
  int          m_stall, m_flush, m_bub;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0; m_mis = 0; m_cc = 0;
      m_stall = 0; m_flush = 0; m_bub = 0; m_ok = 1;
    end else begin
      held = !PCWrite || !IFIDWrite;
      m_cc = held && (Jump || Flush);
      if (!PCWrite && m_stall < CMAX) m_stall++;
      if (Bolha && m_bub < CMAX) m_bub++;
      if (!held) begin
        m_ipc = m_pc;
        if (Jump || Flush) begin
          if (m_flush < CMAX) m_flush++;
          m_instr = NOP;
          m_valid = 0;
        end else begin
          m_instr = word_at(m_pc);
          m_valid = 1;
        end
        if (Jump) begin
          if (jump_target % 4 != 0) m_mis = 1;
          m_pc = jump_target - (jump_target % 4);
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ok) begin
      chk("pc", pc, m_pc);
      chk("IFID_pc", IFID_pc, m_ipc);
      chk("IFID_pc4", IFID_pc4, m_ipc + 32'd4);
      chk("IFID_instr", IFID_instr, m_instr);
      chk("IFID_valid", {31'b0, IFID_valid}, {31'b0, m_valid});
      chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
      chk("ctrl_conflict", {31'b0, ctrl_conflict}, {31'b0, m_cc});
      chk("stall_cnt", {16'b0, stall_cnt}, m_stall);
      chk("flush_cnt", {16'b0, flush_cnt}, m_flush);
      chk("bubble_cnt", {16'b0, bubble_cnt}, m_bub);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(2);
    chk("lit_reset_pc", pc, 32'h0);
    chk("lit_reset_instr", IFID_instr, NOP);
    chk("lit_reset_valid", {31'b0, IFID_valid}, 32'h0);
    chk("lit_reset_cnt", {16'b0, stall_cnt}, 32'h0);
    reset = 1'b0;
    cyc(1);
    chk("lit_t1_pc", pc, 32'h4);
    chk("lit_t1_instr", IFID_instr, 32'hC0DE_0000);
    chk("lit_t1_valid", {31'b0, IFID_valid}, 32'h1);
    cyc(2);
    chk("lit_t1_pc12", pc, 32'hC);
    chk("lit_t1_instr8", IFID_instr, 32'hC0DE_0008);
    chk("lit_t1_pc4", IFID_pc4, 32'hC);
    cyc(1);
    chk("lit_t2_pc", pc, 32'h10);
    PCWrite = 0; IFIDWrite = 0;
    cyc(3);
    chk("lit_t2_hold", pc, 32'h10);
    chk("lit_t2_instr", IFID_instr, 32'hC0DE_000C);
    chk("lit_t2_stall", {16'b0, stall_cnt}, 32'd3);
    PCWrite = 1; IFIDWrite = 1;
    cyc(1);
    chk("lit_t2_resume", pc, 32'h14);
    IFIDWrite = 0;
    cyc(1);
    chk("lit_ifid_hold", pc, 32'h14);
    chk("lit_ifid_nocnt", {16'b0, stall_cnt}, 32'd3);
    IFIDWrite = 1;
    cyc(3);
    chk("lit_t3_pre", pc, 32'h20);
    Jump = 1; jump_target = 32'h200;
    cyc(1);
    Jump = 0;
    chk("lit_t3_pc", pc, 32'h200);
    chk("lit_t3_instr", IFID_instr, NOP);
    chk("lit_t3_valid", {31'b0, IFID_valid}, 32'h0);
    chk("lit_t3_ipc", IFID_pc, 32'h20);
    chk("lit_t3_flush", {16'b0, flush_cnt}, 32'd1);
    cyc(1);
    chk("lit_t3_next", IFID_instr, 32'hC0DE_0200);
    Jump = 1; PCWrite = 0; jump_target = 32'h300;
    cyc(1);
    Jump = 0; PCWrite = 1;
    chk("lit_t4_hold", pc, 32'h204);
    chk("lit_t4_cc", {31'b0, ctrl_conflict}, 32'h1);
    chk("lit_t4_flush", {16'b0, flush_cnt}, 32'd1);
    cyc(1);
    chk("lit_t4_ccoff", {31'b0, ctrl_conflict}, 32'h0);
    Flush = 1;
    cyc(1);
    Flush = 0;
    chk("lit_fl_pc", pc, 32'h20C);
    chk("lit_fl_instr", IFID_instr, NOP);
    chk("lit_fl_cnt", {16'b0, flush_cnt}, 32'd2);
    Jump = 1; jump_target = 32'h102;
    cyc(1);
    Jump = 0;
    chk("lit_t5_pc", pc, 32'h100);
    chk("lit_t5_mis", {31'b0, misalign}, 32'h1);
    cyc(2);
    chk("lit_t5_sticky", {31'b0, misalign}, 32'h1);
    Jump = 1; jump_target = 32'hFFFF_FFFC;
    cyc(1);
    Jump = 0;
    chk("lit_t6_top", pc, 32'hFFFF_FFFC);
    cyc(1);
    chk("lit_t6_wrap", pc, 32'h0);
    chk("lit_t6_pc4", IFID_pc4, 32'h0);
    Bolha = 1;
    cyc(CMAX + 4);
    Bolha = 0;
    chk("lit_t6_sat", {16'b0, bubble_cnt}, 32'h0000_FFFF);
    PCWrite = 0; Jump = 1; jump_target = 32'h400;
    cyc(1);
    reset = 1;
    cyc(1);
    reset = 0; PCWrite = 1; Jump = 0;
    chk("lit_rst_pc", pc, 32'h0);
    chk("lit_rst_mis", {31'b0, misalign}, 32'h0);
    chk("lit_rst_bub", {16'b0, bubble_cnt}, 32'h0);
    cyc(1);
    chk("lit_rst_next", pc, 32'h4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
